// File: rtl/washing_machine_fill_control.sv
// Washing machine drum fill controller: averages load weight samples, picks a
// target water level, opens the inlet valve until the target or a timeout.
module washing_machine_fill_control #(
    parameter int unsigned W_WIDTH        = 8,
    parameter int unsigned L_WIDTH        = 10,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned LOW_TH         = 20,
    parameter int unsigned MED_TH         = 50,
    parameter int unsigned HIGH_TH        = 80,
    parameter int unsigned LVL_LOW        = 100,
    parameter int unsigned LVL_MED        = 200,
    parameter int unsigned LVL_HIGH       = 300,
    parameter int unsigned LVL_XHIGH      = 400,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               clear_fault,
    input  logic [W_WIDTH-1:0] load_weight,
    input  logic [L_WIDTH-1:0] level_sensor,
    output logic [L_WIDTH-1:0] water_level,
    output logic               fill_valve,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    localparam int unsigned ACC_W = W_WIDTH + AVG_LOG2;
    localparam int unsigned NSAMP = 1 << AVG_LOG2;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WEIGH  = 3'd1,
        S_SELECT = 3'd2,
        S_FILL   = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_samp_cnt;
    logic [CNT_W-1:0]    r_fill_cnt;
    logic                w_last_samp;
    logic                w_target_met;
    logic                w_timeout;
    logic [W_WIDTH-1:0]  w_avg;
    logic [L_WIDTH-1:0]  w_level_sel;
    logic                w_fill_valve;
    logic                w_busy;
    logic                w_done;
    logic                w_fault;

    assign w_last_samp  = (r_samp_cnt == AVG_LOG2'(NSAMP - 1));
    assign w_target_met = (level_sensor >= water_level);
    assign w_timeout    = (r_fill_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_avg        = W_WIDTH'(r_acc >> AVG_LOG2);

    // Map truncated average weight to a target level
    always_comb begin
        w_level_sel = L_WIDTH'(LVL_XHIGH);
        if (w_avg <= W_WIDTH'(LOW_TH))
            w_level_sel = L_WIDTH'(LVL_LOW);
        else if (w_avg <= W_WIDTH'(MED_TH))
            w_level_sel = L_WIDTH'(LVL_MED);
        else if (w_avg <= W_WIDTH'(HIGH_TH))
            w_level_sel = L_WIDTH'(LVL_HIGH);
    end

    // Next state; outputs are decoded from the next state so they register with it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_WEIGH;
            S_WEIGH:  begin
                if (abort)            w_state_nxt = S_IDLE;
                else if (w_last_samp) w_state_nxt = S_SELECT;
            end
            S_SELECT: w_state_nxt = abort ? S_IDLE : S_FILL;
            S_FILL:   begin
                if (abort)             w_state_nxt = S_IDLE;
                else if (w_target_met) w_state_nxt = S_DONE;
                else if (w_timeout)    w_state_nxt = S_FAULT;
            end
            S_DONE:   w_state_nxt = S_IDLE;
            S_FAULT:  if (clear_fault) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        w_fill_valve = (w_state_nxt == S_FILL);
        w_busy       = (w_state_nxt == S_WEIGH) || (w_state_nxt == S_SELECT) ||
                       (w_state_nxt == S_FILL);
        w_done       = (w_state_nxt == S_DONE);
        w_fault      = (w_state_nxt == S_FAULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            fill_valve <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            fill_valve <= w_fill_valve;
            busy       <= w_busy;
            done       <= w_done;
            fault      <= w_fault;
        end
    end

    // Weight accumulation, fill timeout counter and target level register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_samp_cnt  <= '0;
            r_fill_cnt  <= '0;
            water_level <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_acc      <= '0;
                r_samp_cnt <= '0;
            end else if (r_state == S_WEIGH) begin
                r_acc      <= r_acc + ACC_W'(load_weight);
                r_samp_cnt <= r_samp_cnt + AVG_LOG2'(1);
            end

            if (r_state == S_SELECT) begin
                water_level <= w_level_sel;
                r_fill_cnt  <= '0;
            end else if (r_state == S_FILL) begin
                r_fill_cnt  <= r_fill_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_washing_machine_fill_control.sv
// Scoreboard bench for the fill controller: completion events (done pulse or
// fault entry) are queued at stimulus time and checked by a separate monitor.
module tb_washing_machine_fill_control;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       clear_fault;
    logic [7:0] load_weight;
    logic [9:0] level_sensor;
    logic [9:0] water_level;
    logic       fill_valve;
    logic       busy;
    logic       done;
    logic       fault;

    typedef struct {
        logic       is_fault;
        logic [9:0] wl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_fault = 1'b0;

    washing_machine_fill_control #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .clear_fault (clear_fault),
        .load_weight (load_weight),
        .level_sensor(level_sensor),
        .water_level (water_level),
        .fill_valve  (fill_valve),
        .busy        (busy),
        .done        (done),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic push_exp(input logic is_fault, input logic [9:0] wl);
        exp_t e;
        e.is_fault = is_fault;
        e.wl       = wl;
        exp_q.push_back(e);
    endtask

    // Start a cycle and feed four weight samples; returns at the negedge after FILL entry
    task automatic run_weigh(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0; load_weight = s0;
        @(negedge clk) load_weight = s1;
        @(negedge clk) load_weight = s2;
        @(negedge clk) load_weight = s3;
        @(negedge clk);
        chk("select_busy", busy, 1);
        @(negedge clk);
    endtask

    // Monitor: every done pulse or fault entry consumes one expected event
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1 || (fault === 1'b1 && prev_fault !== 1'b1)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got done=%0b fault=%0b expected none", done, fault);
            end else begin
                e = exp_q.pop_front();
                chk("event_fault", fault, e.is_fault);
                chk("event_level", water_level, e.wl);
            end
        end
        prev_fault = fault;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bvals [6];
        logic [9:0] blvls [6];
        bvals = '{8'd20, 8'd21, 8'd50, 8'd80, 8'd81, 8'd255};
        blvls = '{10'd100, 10'd200, 10'd200, 10'd300, 10'd400, 10'd400};

        reset        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        clear_fault  = 1'b0;
        load_weight  = '0;
        level_sensor = '0;
        #3;
        chk("rst_level", water_level, 0);
        chk("rst_valve", fill_valve, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        @(negedge clk) reset = 1'b1;

        // Nominal run: target 100, valve open until sensor reaches it
        level_sensor = 10'd0;
        push_exp(1'b0, 10'd100);
        run_weigh(8'd10, 8'd10, 8'd10, 8'd10);
        chk("nom_level", water_level, 100);
        chk("nom_valve_open", fill_valve, 1);
        chk("nom_busy", busy, 1);
        repeat (2) @(negedge clk);
        chk("nom_valve_still", fill_valve, 1);
        level_sensor = 10'd100;
        @(negedge clk);
        chk("nom_valve_closed", fill_valve, 0);
        chk("nom_done", done, 1);
        @(negedge clk);
        chk("nom_done_one_cycle", done, 0);
        chk("nom_idle_busy", busy, 0);

        // Threshold boundaries with the sensor already above any target
        for (int i = 0; i < 6; i++) begin
            level_sensor = 10'd1023;
            push_exp(1'b0, blvls[i]);
            run_weigh(bvals[i], bvals[i], bvals[i], bvals[i]);
            chk("bnd_level", water_level, blvls[i]);
            chk("bnd_valve", fill_valve, 1);
            @(negedge clk);
            chk("bnd_valve_closed", fill_valve, 0);
            @(negedge clk);
            chk("bnd_idle_done", done, 0);
        end

        // Truncating average: 123/4 -> 30 -> medium level
        level_sensor = 10'd1023;
        push_exp(1'b0, 10'd200);
        run_weigh(8'd30, 8'd30, 8'd30, 8'd33);
        chk("avg_level", water_level, 200);
        repeat (2) @(negedge clk);

        // Timeout into FAULT after 16 FILL cycles
        level_sensor = 10'd0;
        push_exp(1'b1, 10'd100);
        run_weigh(8'd10, 8'd10, 8'd10, 8'd10);
        repeat (15) @(negedge clk);
        chk("to_pre_fault", fault, 0);
        chk("to_pre_valve", fill_valve, 1);
        @(negedge clk);
        chk("to_fault", fault, 1);
        chk("to_valve", fill_valve, 0);
        chk("to_busy", busy, 0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        chk("to_start_ignored", fault, 1);
        chk("to_start_busy", busy, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("to_abort_ignored", fault, 1);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        chk("to_cleared", fault, 0);
        chk("to_cleared_busy", busy, 0);

        // Target met on the timeout edge: DONE wins
        level_sensor = 10'd0;
        push_exp(1'b0, 10'd100);
        run_weigh(8'd10, 8'd10, 8'd10, 8'd10);
        repeat (15) @(negedge clk);
        level_sensor = 10'd100;
        @(negedge clk);
        chk("sim_fault", fault, 0);
        chk("sim_done", done, 1);
        chk("sim_valve", fill_valve, 0);
        @(negedge clk);

        // Abort in FILL keeps the selected level
        level_sensor = 10'd0;
        run_weigh(8'd30, 8'd30, 8'd30, 8'd33);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valve", fill_valve, 0);
        chk("abort_busy", busy, 0);
        chk("abort_level_held", water_level, 200);
        @(negedge clk);
        chk("abort_no_done", done, 0);

        // Asynchronous reset mid-FILL, then start on the first edge
        run_weigh(8'd255, 8'd255, 8'd255, 8'd255);
        chk("pre_rst_valve", fill_valve, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_level", water_level, 0);
        chk("arst_valve", fill_valve, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_fault", fault, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("first_start_busy", busy, 1);
        start = 1'b0;
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("final_idle", busy, 0);

        repeat (3) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
